// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for a bus-based register-file ALU: it walks one
// captured instruction through read-A, read-B, execute and write-back strobes.
module alu_seq_ctrl #(
  parameter int         NUM_REGS  = 5,
  parameter logic [3:0] UNARY_OPC = 4'b1110,
  parameter logic [3:0] OPC_MIN   = 4'b1000,
  parameter logic [3:0] OPC_MAX   = 4'b1110
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         instruction,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                pc_inc,
  output logic                alu_in0,
  output logic                alu_in1,
  output logic                alu_out_latch,
  output logic                alu_out_en,
  output logic [NUM_REGS-1:0] rx_out,
  output logic [NUM_REGS-1:0] rx_in
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] RDA_SETUP = 4'd1;
  localparam logic [3:0] RDA_LATCH = 4'd2;
  localparam logic [3:0] GAP       = 4'd3;
  localparam logic [3:0] RDB_SETUP = 4'd4;
  localparam logic [3:0] RDB_LATCH = 4'd5;
  localparam logic [3:0] EXEC      = 4'd6;
  localparam logic [3:0] OUT_DRV   = 4'd7;
  localparam logic [3:0] WB        = 4'd8;
  localparam logic [3:0] DONE      = 4'd9;
  localparam logic [3:0] ERR       = 4'd10;

  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

  logic [3:0]  state;
  logic [3:0]  next_state;
  logic [15:0] instr_q;

  logic        is_alu;
  logic        is_unary_in;
  logic        idx_ok;
  logic        accept;
  logic        is_unary_q;

  // Register index i drives rx bit NUM_REGS-1-i, so index 0 lands on the MSB.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [5:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int j = 0; j < NUM_REGS; j++) begin
      if ({1'b0, idx} == 7'(NUM_REGS - 1 - j)) v[j] = 1'b1;
    end
    return v;
  endfunction

  assign is_alu      = (instruction[15:12] >= OPC_MIN) && (instruction[15:12] <= OPC_MAX);
  assign is_unary_in = (instruction[15:12] == UNARY_OPC);
  assign idx_ok      = ({1'b0, instruction[11:6]} < NUM_REGS_W) &&
                       (is_unary_in || ({1'b0, instruction[5:0]} < NUM_REGS_W));
  assign accept      = start && (state == IDLE) && is_alu;
  assign is_unary_q  = (instr_q[15:12] == UNARY_OPC);

  // The instruction is frozen at accept so later bus activity cannot disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      instr_q <= '0;
    end else begin
      state <= next_state;
      if (accept) instr_q <= instruction;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:      next_state = accept ? (idx_ok ? RDA_SETUP : ERR) : IDLE;
      RDA_SETUP: next_state = RDA_LATCH;
      RDA_LATCH: next_state = is_unary_q ? EXEC : GAP;
      GAP:       next_state = RDB_SETUP;
      RDB_SETUP: next_state = RDB_LATCH;
      RDB_LATCH: next_state = EXEC;
      EXEC:      next_state = OUT_DRV;
      OUT_DRV:   next_state = WB;
      WB:        next_state = DONE;
      DONE:      next_state = IDLE;
      ERR:       next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Pure Moore decode; unused encodings fall through with every output low.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    pc_inc        = 1'b0;
    alu_in0       = 1'b0;
    alu_in1       = 1'b0;
    alu_out_latch = 1'b0;
    alu_out_en    = 1'b0;
    rx_out        = '0;
    rx_in         = '0;
    case (state)
      RDA_SETUP: begin
        busy   = 1'b1;
        pc_inc = 1'b1;
        rx_out = onehot(instr_q[11:6]);
      end
      RDA_LATCH: begin
        busy    = 1'b1;
        alu_in0 = 1'b1;
        rx_out  = onehot(instr_q[11:6]);
      end
      GAP: busy = 1'b1;
      RDB_SETUP: begin
        busy   = 1'b1;
        rx_out = onehot(instr_q[5:0]);
      end
      RDB_LATCH: begin
        busy    = 1'b1;
        alu_in1 = 1'b1;
        rx_out  = onehot(instr_q[5:0]);
      end
      EXEC: begin
        busy          = 1'b1;
        alu_out_latch = 1'b1;
      end
      OUT_DRV: begin
        busy       = 1'b1;
        alu_out_en = 1'b1;
      end
      WB: begin
        busy       = 1'b1;
        alu_out_en = 1'b1;
        rx_in      = onehot(instr_q[11:6]);
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      ERR: begin
        busy   = 1'b1;
        done   = 1'b1;
        err    = 1'b1;
        pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a 5-register and an 8-register instance
// checked cycle by cycle against a hand-written expected strobe trace.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start5, start8;
  logic [15:0] instr5, instr8;

  logic busy5, done5, err5, pc5, in0_5, in1_5, olat5, oen5;
  logic [4:0] rx_out5, rx_in5;
  logic busy8, done8, err8, pc8, in0_8, in1_8, olat8, oen8;
  logic [7:0] rx_out8, rx_in8;

  alu_seq_ctrl #(.NUM_REGS(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .instruction(instr5),
    .busy(busy5), .done(done5), .err(err5), .pc_inc(pc5),
    .alu_in0(in0_5), .alu_in1(in1_5), .alu_out_latch(olat5), .alu_out_en(oen5),
    .rx_out(rx_out5), .rx_in(rx_in5)
  );

  alu_seq_ctrl #(.NUM_REGS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .instruction(instr8),
    .busy(busy8), .done(done8), .err(err8), .pc_inc(pc8),
    .alu_in0(in0_8), .alu_in1(in1_8), .alu_out_latch(olat8), .alu_out_en(oen8),
    .rx_out(rx_out8), .rx_in(rx_in8)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       pc_inc;
    logic       alu_in0;
    logic       alu_in1;
    logic       alu_out_latch;
    logic       alu_out_en;
    logic [7:0] rx_out;
    logic [7:0] rx_in;
  } outs_t;

  // kind: 0 = binary, 1 = unary, 2 = rejected
  typedef struct {
    logic [15:0] instr;
    int          kind;
    logic [7:0]  one_a;
    logic [7:0]  one_b;
    string       name;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int pc_cnt5 = 0;
  int pc_cnt8 = 0;
  int exp_pc5 = 0;
  int exp_pc8 = 0;

  always @(posedge clk) begin
    if (rst && pc5) pc_cnt5 <= pc_cnt5 + 1;
    if (rst && pc8) pc_cnt8 <= pc_cnt8 + 1;
  end

  function automatic outs_t actual(input bit sel);
    outs_t o;
    if (!sel) o = '{busy5, done5, err5, pc5, in0_5, in1_5, olat5, oen5, {3'b0, rx_out5}, {3'b0, rx_in5}};
    else      o = '{busy8, done8, err8, pc8, in0_8, in1_8, olat8, oen8, rx_out8, rx_in8};
    return o;
  endfunction

  // Expected outputs k cycles after the accepting edge; unary skips GAP/RDB_*.
  function automatic outs_t expected(input int k, input int kind, input logic [7:0] one_a, input logic [7:0] one_b);
    outs_t e;
    int len;
    int s;
    e = '0;
    len = (kind == 0) ? 9 : ((kind == 1) ? 6 : 1);
    if (k < 1 || k > len) return e;
    e.busy = 1'b1;
    if (kind == 2) begin
      e.done = 1'b1; e.err = 1'b1; e.pc_inc = 1'b1;
      return e;
    end
    s = (kind == 1 && k >= 3) ? k + 3 : k;
    case (s)
      1: begin e.pc_inc = 1'b1; e.rx_out = one_a; end
      2: begin e.alu_in0 = 1'b1; e.rx_out = one_a; end
      4: e.rx_out = one_b;
      5: begin e.alu_in1 = 1'b1; e.rx_out = one_b; end
      6: e.alu_out_latch = 1'b1;
      7: e.alu_out_en = 1'b1;
      8: begin e.alu_out_en = 1'b1; e.rx_in = one_a; end
      9: e.done = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input int k, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, k, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic [15:0] ins);
    if (!sel) begin start5 = s; instr5 = ins; end
    else      begin start8 = s; instr8 = ins; end
  endtask

  // Called in the low clock phase; accepts on the next rising edge and follows
  // the run through to the IDLE cycle. With poke set, start stays high and the
  // instruction input is changed while busy.
  task automatic applyStimulus(input bit sel, input vec_t v, input bit poke);
    int len;
    len = (v.kind == 0) ? 9 : ((v.kind == 1) ? 6 : 1);
    drive(sel, 1'b1, v.instr);
    @(posedge clk);
    #1;
    if (poke) drive(sel, 1'b1, 16'hE0C0);
    else      drive(sel, 1'b0, v.instr);
    if (!sel) exp_pc5++; else exp_pc8++;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      checkOutput(v.name, k, actual(sel), expected(k, v.kind, v.one_a, v.one_b));
      if (poke && k == len) drive(sel, 1'b0, 16'h0000);
    end
  endtask

  task automatic checkIgnored(input logic [15:0] ins, input string name);
    drive(1'b0, 1'b1, ins);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checkOutput(name, k, actual(1'b0), '0);
    end
    drive(1'b0, 1'b0, 16'h0000);
  endtask

  vec_t vecs[10];
  vec_t v;

  initial begin
    vecs[0] = '{16'h8042, 0, 8'b01000, 8'b00100, "bin_a1_b2"};
    vecs[1] = '{16'hE0C0, 1, 8'b00010, 8'b00000, "unary_a3"};
    vecs[2] = '{16'h8145, 2, 8'b00000, 8'b00000, "err_a5"};
    vecs[3] = '{16'h9000, 0, 8'b10000, 8'b10000, "bin_a0_b0"};
    vecs[4] = '{16'hD104, 0, 8'b00001, 8'b00001, "bin_a4_b4"};
    vecs[5] = '{16'hE0C7, 1, 8'b00010, 8'b00000, "unary_bad_b_ignored"};
    vecs[6] = '{16'h8047, 2, 8'b00000, 8'b00000, "err_b7"};
    vecs[7] = '{16'hEFC0, 2, 8'b00000, 8'b00000, "err_a63"};
    vecs[8] = '{16'hC0C1, 0, 8'b00010, 8'b01000, "bin_a3_b1"};
    vecs[9] = '{16'h8042, 0, 8'b01000, 8'b00100, "bin_back_to_back"};

    rst = 1'b0;
    start5 = 1'b0; start8 = 1'b0;
    instr5 = 16'h0000; instr8 = 16'h0000;
    repeat (2) @(negedge clk);
    checkOutput("reset_dut5", 0, actual(1'b0), '0);
    checkOutput("reset_dut8", 0, actual(1'b1), '0);
    rst = 1'b1;

    foreach (vecs[i]) applyStimulus(1'b0, vecs[i], 1'b0);

    checkIgnored(16'h3042, "ignore_opc3");
    checkIgnored(16'hF042, "ignore_opcF");

    v = '{16'h8042, 0, 8'b01000, 8'b00100, "start_while_busy"};
    applyStimulus(1'b0, v, 1'b1);

    // Abort during RDB_LATCH: outputs must clear without a clock edge.
    drive(1'b0, 1'b1, 16'h8042);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 16'h8042);
    exp_pc5++;
    repeat (5) @(negedge clk);
    checkOutput("abort_before", 5, actual(1'b0), expected(5, 0, 8'b01000, 8'b00100));
    #2 rst = 1'b0;
    #1 checkOutput("abort_async", 0, actual(1'b0), '0);
    @(negedge clk);
    checkOutput("abort_held", 0, actual(1'b0), '0);
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("abort_no_done", k, actual(1'b0), '0);
    end
    v = '{16'h8042, 0, 8'b01000, 8'b00100, "after_abort"};
    applyStimulus(1'b0, v, 1'b0);

    v = '{16'h81C0, 0, 8'b00000001, 8'b10000000, "r8_a7_b0"};
    applyStimulus(1'b1, v, 1'b0);
    v = '{16'hA007, 0, 8'b10000000, 8'b00000001, "r8_a0_b7"};
    applyStimulus(1'b1, v, 1'b0);

    @(negedge clk);
    checks++;
    if (pc_cnt5 != exp_pc5) begin
      failures++;
      $display("[TB] FAIL pc_count_dut5: got %0d expected %0d", pc_cnt5, exp_pc5);
    end
    checks++;
    if (pc_cnt8 != exp_pc8) begin
      failures++;
      $display("[TB] FAIL pc_count_dut8: got %0d expected %0d", pc_cnt8, exp_pc8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
